// File: rtl/mult_seq_pkg.sv
// Shared types, widths and the step-to-shift lookup for the sequential 8x8 multiplier.
// The zero-skip option (MULT_SEQ_ZERO_SKIP_EN) is selected in mult_seq_ctrl.sv.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_W = 2;
  localparam int OPND_W = 8;
  localparam int PROD_W = 16;
  localparam int NIB_W  = 4;

  // Steps 1 and 2 are the two cross terms; both land at bit 4.
  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    case (step)
      2'd0:    return 4'd0;
      2'd3:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_main.sv
// 4x4 unsigned array multiplier core (module main): purely combinational,
// sums the four shifted AND rows of x against the bits of y.
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  logic [7:0] row [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      row[i] = y[i] ? (8'(x) << i) : 8'd0;
    end
  end

  assign o = row[0] + row[1] + row[2] + row[3];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: four nibble products through one shared 4x4 core,
// valid/ready on both sides. Optional macro MULT_SEQ_ZERO_SKIP_EN short-cuts zero operands.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid may not depend on ready, and the producer holds data while valid && !ready.
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPND_W-1:0]   in_a,
  input  logic [OPND_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_p,
  output logic [TAG_W-1:0]    out_tag
);

  state_t              state_q;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [PROD_W-1:0]   acc;
  logic [STEP_W-1:0]   step;

  logic [NIB_W-1:0]    core_x;
  logic [NIB_W-1:0]    core_y;
  logic [OPND_W-1:0]   core_o;
  logic [PROD_W-1:0]   partial;

  // step[1] picks the a nibble, step[0] the b nibble; idle the core outside CALC.
  always_comb begin
    core_x = '0;
    core_y = '0;
    if (state_q == CALC) begin
      core_x = step[1] ? a_q[7:4] : a_q[3:0];
      core_y = step[0] ? b_q[7:4] : b_q[3:0];
    end
  end

  main u_core (
    .x (core_x),
    .y (core_y),
    .o (core_o)
  );

  assign partial = {8'b0, core_o} << step_shift(step);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      acc     <= '0;
      step    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            acc   <= '0;
            step  <= '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if ((in_a == '0) || (in_b == '0)) state_q <= DONE;
            else                              state_q <= CALC;
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          acc  <= acc + partial;
          step <= step + 1'b1;
          if (step == 2'd3) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_p     = acc;
  assign out_tag   = tag_q;

endmodule
